// File: rtl/ddr_cmd_scheduler.sv
// Closed-page, single-bank DDR command sequencer: ACT -> CAS -> data -> PRE,
// with periodic refresh. Strobes are registered, one cycle wide.
module ddr_cmd_scheduler #(
  parameter int unsigned T_RCD  = 16,
  parameter int unsigned T_RAS  = 39,
  parameter int unsigned T_WR   = 18,
  parameter int unsigned T_RP   = 16,
  parameter int unsigned T_REFI = 512,
  parameter int unsigned T_RFC  = 64,
  parameter int unsigned TW     = 16
) (
  input  logic       clock_t,
  input  logic       reset,
  input  logic       init_done,
  input  logic       req_valid,
  input  logic [1:0] req_rw,
  output logic       req_ready,
  input  logic [7:0] rd_delay,
  input  logic [7:0] wr_delay,
  input  logic [3:0] bl,
  output logic       act_rdy,
  output logic       cas_rdy,
  output logic       rw_rdy,
  output logic       pre_rdy,
  output logic       refresh_rdy,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ACT, WAIT_RCD, CAS, WAIT_DATA, WAIT_PRE, PRE, WAIT_RP, REF, WAIT_RFC
  } state_t;

  localparam logic [TW-1:0] RCD_LOAD  = TW'(T_RCD - 1);
  localparam logic [TW-1:0] RAS_MIN   = TW'(T_RAS - 1);
  localparam logic [TW-1:0] WR_CYC    = TW'(T_WR);
  localparam logic [TW-1:0] RP_LOAD   = TW'(T_RP - 1);
  localparam logic [TW-1:0] RFC_LOAD  = TW'(T_RFC - 1);
  localparam logic [TW-1:0] REFI_LAST = TW'(T_REFI - 1);

  state_t        state;
  logic [TW-1:0] rcd_t;
  logic [TW-1:0] ras_t;
  logic [TW-1:0] data_t;
  logic [TW-1:0] post_t;
  logic [TW-1:0] rp_t;
  logic [TW-1:0] rfc_t;
  logic [TW-1:0] refi_t;
  logic          ref_pending;
  logic [1:0]    rw_q;
  logic          is_write;
  logic [7:0]    cas_delay;
  logic [TW-1:0] post_load;
  logic          ref_take;

  // Illegal codes (00/11) fall through to READ timing.
  assign is_write  = (rw_q == 2'b10);
  assign cas_delay = is_write ? wr_delay : rd_delay;
  assign post_load = TW'(bl >> 1) + (is_write ? WR_CYC : '0);
  assign ref_take  = (state == IDLE) && init_done && ref_pending;

  assign busy      = (state != IDLE);
  assign req_ready = !reset && (state == IDLE) && init_done && !ref_pending;

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      refi_t      <= '0;
      ref_pending <= 1'b0;
    end else begin
      if (ref_take)
        ref_pending <= 1'b0;
      // A fresh expiry wins over the clear; there is no postponement credit.
      if (init_done) begin
        if (refi_t == REFI_LAST) begin
          refi_t      <= '0;
          ref_pending <= 1'b1;
        end else begin
          refi_t <= refi_t + 1'b1;
        end
      end
    end
  end

  // Strobes are raised on the edge entering their state, so every wait
  // state decides one cycle ahead (hence the <=1 / <=2 thresholds).
  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rcd_t       <= '0;
      ras_t       <= '0;
      data_t      <= '0;
      post_t      <= '0;
      rp_t        <= '0;
      rfc_t       <= '0;
      rw_q        <= '0;
      act_rdy     <= 1'b0;
      cas_rdy     <= 1'b0;
      rw_rdy      <= 1'b0;
      pre_rdy     <= 1'b0;
      refresh_rdy <= 1'b0;
    end else begin
      if (ras_t != '1)
        ras_t <= ras_t + 1'b1;
      case (state)
        IDLE: begin
          if (init_done) begin
            if (ref_pending) begin
              state       <= REF;
              refresh_rdy <= 1'b1;
            end else if (req_valid) begin
              state   <= ACT;
              act_rdy <= 1'b1;
              rw_q    <= req_rw;
              ras_t   <= '0;
            end
          end
        end
        ACT: begin
          act_rdy <= 1'b0;
          rcd_t   <= RCD_LOAD;
          state   <= WAIT_RCD;
        end
        WAIT_RCD: begin
          if (rcd_t <= TW'(1)) begin
            rcd_t   <= '0;
            cas_rdy <= 1'b1;
            state   <= CAS;
          end else begin
            rcd_t <= rcd_t - 1'b1;
          end
        end
        CAS: begin
          cas_rdy <= 1'b0;
          data_t  <= TW'(cas_delay);
          rw_rdy  <= (cas_delay <= 8'd1);
          state   <= WAIT_DATA;
        end
        WAIT_DATA: begin
          if (rw_rdy) begin
            rw_rdy <= 1'b0;
            post_t <= post_load;
            state  <= WAIT_PRE;
          end else begin
            data_t <= data_t - 1'b1;
            rw_rdy <= (data_t == TW'(2));
          end
        end
        WAIT_PRE: begin
          if ((post_t <= TW'(2)) && (ras_t >= RAS_MIN)) begin
            pre_rdy <= 1'b1;
            state   <= PRE;
          end else if (post_t != '0) begin
            post_t <= post_t - 1'b1;
          end
        end
        PRE: begin
          pre_rdy <= 1'b0;
          rp_t    <= RP_LOAD;
          state   <= WAIT_RP;
        end
        WAIT_RP: begin
          if (rp_t <= TW'(1))
            state <= IDLE;
          else
            rp_t <= rp_t - 1'b1;
        end
        REF: begin
          refresh_rdy <= 1'b0;
          rfc_t       <= RFC_LOAD;
          state       <= WAIT_RFC;
        end
        WAIT_RFC: begin
          if (rfc_t <= TW'(1))
            state <= IDLE;
          else
            rfc_t <= rfc_t - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Scoreboard bench for ddr_cmd_scheduler: expected strobe cycles are queued
// when a request is issued and compared against the DUT every cycle.
module tb_ddr_cmd_scheduler;

  localparam int unsigned TB_RCD  = 16;
  localparam int unsigned TB_RAS  = 39;
  localparam int unsigned TB_WR   = 18;
  localparam int unsigned TB_RP   = 16;
  localparam int unsigned TB_REFI = 512;
  localparam int unsigned TB_RFC  = 64;

  localparam logic [4:0] E_ACT = 5'b10000;
  localparam logic [4:0] E_CAS = 5'b01000;
  localparam logic [4:0] E_RW  = 5'b00100;
  localparam logic [4:0] E_PRE = 5'b00010;
  localparam logic [4:0] E_REF = 5'b00001;

  logic       clock_t = 1'b0;
  logic       reset;
  logic       init_done;
  logic       req_valid;
  logic [1:0] req_rw;
  logic       req_ready;
  logic [7:0] rd_delay;
  logic [7:0] wr_delay;
  logic [3:0] bl;
  logic       act_rdy, cas_rdy, rw_rdy, pre_rdy, refresh_rdy, busy;

  ddr_cmd_scheduler #(
    .T_RCD(TB_RCD), .T_RAS(TB_RAS), .T_WR(TB_WR), .T_RP(TB_RP),
    .T_REFI(TB_REFI), .T_RFC(TB_RFC), .TW(16)
  ) dut (
    .clock_t(clock_t), .reset(reset), .init_done(init_done),
    .req_valid(req_valid), .req_rw(req_rw), .req_ready(req_ready),
    .rd_delay(rd_delay), .wr_delay(wr_delay), .bl(bl),
    .act_rdy(act_rdy), .cas_rdy(cas_rdy), .rw_rdy(rw_rdy),
    .pre_rdy(pre_rdy), .refresh_rdy(refresh_rdy), .busy(busy)
  );

  always #5 clock_t = ~clock_t;

  int unsigned cyc = 0;
  always @(posedge clock_t) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  s;
  } ev_t;

  ev_t q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int unsigned c, input logic [4:0] s);
    int unsigned i;
    ev_t e;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    e.cyc = c;
    e.s   = s;
    q.insert(i, e);
  endfunction

  // Strobe monitor: every cycle either matches the queue head or is silent.
  always @(negedge clock_t) begin : monitor
    logic [4:0] obs;
    ev_t        e;
    obs = {act_rdy, cas_rdy, rw_rdy, pre_rdy, refresh_rdy};
    if (q.size() != 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      check_eq("strobe", {59'd0, obs}, {59'd0, e.s});
    end else if (obs != 5'd0) begin
      check_eq("unexpected_strobe", {59'd0, obs}, 64'd0);
    end
  end

  task automatic wait_cycle(input int unsigned c);
    while (cyc < c) @(negedge clock_t);
  endtask

  task automatic do_txn(input logic [1:0] rw, input logic [7:0] rdd, input logic [7:0] wrd,
                        input logic [3:0] blv, input bit abort,
                        output int unsigned t, output int unsigned idle_c);
    int unsigned d, rwc, p, pre;
    bit got;
    got = 1'b0;
    req_rw    = rw;
    rd_delay  = rdd;
    wr_delay  = wrd;
    bl        = blv;
    req_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (req_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clock_t);
    end
    if (!got) begin
      check_eq("handshake_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      t = cyc;
      idle_c = cyc;
      return;
    end
    t   = cyc + 1;
    d   = (rw == 2'b10) ? int'(wrd) : int'(rdd);
    if (d == 0) d = 1;
    rwc = t + TB_RCD + d;
    p   = int'(blv) / 2 + ((rw == 2'b10) ? TB_WR : 0);
    pre = rwc + p;
    if (pre < t + TB_RAS) pre = t + TB_RAS;
    idle_c = pre + TB_RP;
    push_ev(t, E_ACT);
    push_ev(t + TB_RCD, E_CAS);
    if (!abort) begin
      push_ev(rwc, E_RW);
      push_ev(pre, E_PRE);
    end
    @(negedge clock_t);
    req_valid = 1'b0;
  endtask

  task automatic finish_txn(input int unsigned idle_c);
    wait_cycle(idle_c - 1);
    check_eq("busy_before_idle", {63'd0, busy}, 64'd1);
    check_eq("ready_before_idle", {63'd0, req_ready}, 64'd0);
    @(negedge clock_t);
    check_eq("ready_at_idle", {63'd0, req_ready}, 64'd1);
    check_eq("busy_at_idle", {63'd0, busy}, 64'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int unsigned t, ic, c0, rr;
    reset     = 1'b1;
    init_done = 1'b0;
    req_valid = 1'b1;
    req_rw    = 2'b01;
    rd_delay  = 8'd20;
    wr_delay  = 8'd10;
    bl        = 4'd8;
    repeat (2) @(negedge clock_t);
    #1;
    check_eq("reset_outputs",
             {57'd0, act_rdy, cas_rdy, rw_rdy, pre_rdy, refresh_rdy, busy, req_ready}, 64'd0);
    @(negedge clock_t);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock_t);
      check_eq("no_init_idle", {62'd0, req_ready, busy}, 64'd0);
    end

    req_valid = 1'b0;
    @(negedge clock_t);
    init_done = 1'b1;
    c0 = cyc;
    push_ev(c0 + TB_REFI + 1, E_REF);
    #1;
    check_eq("ready_after_init", {63'd0, req_ready}, 64'd1);

    // READ; rd_delay changed after CAS must not move rw_rdy
    do_txn(2'b01, 8'd20, 8'd10, 4'd8, 1'b0, t, ic);
    wait_cycle(t + TB_RCD + 1);
    rd_delay = 8'd3;
    finish_txn(ic);

    do_txn(2'b10, 8'd3, 8'd10, 4'd8, 1'b0, t, ic);
    finish_txn(ic);

    // tRAS-limited READ
    do_txn(2'b01, 8'd2, 8'd7, 4'd4, 1'b0, t, ic);
    finish_txn(ic);

    // Illegal code 11 with zero read delay: READ timing, rw_rdy right after CAS
    do_txn(2'b11, 8'd0, 8'd9, 4'd4, 1'b0, t, ic);
    finish_txn(ic);

    // Refresh and request collide in IDLE
    wait_cycle(c0 + TB_REFI);
    check_eq("ref_pending_blocks", {63'd0, req_ready}, 64'd0);
    do_txn(2'b01, 8'd5, 8'd5, 4'd8, 1'b0, t, ic);
    check_eq("ref_first_handshake", 64'(t - 1), 64'(c0 + TB_REFI + 1 + TB_RFC));
    finish_txn(ic);

    // Async reset during WAIT_DATA
    do_txn(2'b01, 8'd30, 8'd30, 4'd8, 1'b1, t, ic);
    wait_cycle(t + TB_RCD + 4);
    reset = 1'b1;
    #1;
    check_eq("reset_mid_outputs",
             {57'd0, act_rdy, cas_rdy, rw_rdy, pre_rdy, refresh_rdy, busy, req_ready}, 64'd0);
    repeat (3) @(negedge clock_t);
    reset = 1'b0;
    rr = cyc;
    push_ev(rr + TB_REFI + 1, E_REF);
    #1;
    check_eq("idle_after_reset", {62'd0, busy, req_ready}, 64'd1);
    wait_cycle(rr + TB_REFI + 8);

    check_eq("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_scheduler.md
Name: ddr_cmd_scheduler

Overview:
- Sequences the per-transaction command strobes that drive the burst-data datapath: act_rdy, cas_rdy, rw_rdy, pre_rdy and refresh_rdy.
- Closed-page, single-bank policy. One transaction is in flight at a time: ACT, wait tRCD, CAS, data phase, PRE, wait tRP.
- Inserts periodic refresh.
- Sits between the transaction source (requester handshake) and the burst-data/command-pin logic. Takes RD/WR delays and BL from the mode-register decode.

Parameters:
- T_RCD, 16, ACT-to-CAS cycles
- T_RAS, 39, ACT-to-PRE minimum cycles
- T_WR, 18, cycles from end of write data to PRE
- T_RP, 16, PRE-to-next-ACT/REF cycles
- T_REFI, 512, cycles between refresh requests
- T_RFC, 64, REF-to-next-command cycles
- TW, 16, width of all internal timers

Ports:
- clock_t  in  1  main clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- init_done  in  1  MRS/ZQ init complete; no scheduling while low
- req_valid  in  1  transaction available
- req_rw  in  2  01=READ, 10=WRITE; other codes are illegal
- req_ready  out  1  transaction accepted this cycle when req_valid&&req_ready
- rd_delay  in  8  CAS-to-read-data cycles (CL+AL-RPRE)
- wr_delay  in  8  CAS-to-write-data cycles (CWL+AL-WPRE)
- bl  in  4  burst length, 4 or 8
- act_rdy  out  1  one-cycle ACT strobe
- cas_rdy  out  1  one-cycle CAS strobe
- rw_rdy  out  1  one-cycle data-phase start strobe
- pre_rdy  out  1  one-cycle PRE strobe
- refresh_rdy  out  1  one-cycle REF strobe
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, active-high):
  - FSM goes to IDLE; all timers clear.
  - ref_pending=0; all outputs 0.
  - Reset mid-transaction abandons the transaction with no further strobes.
- FSM states: IDLE, ACT, WAIT_RCD, CAS, WAIT_DATA, WAIT_PRE, PRE, WAIT_RP, REF, WAIT_RFC.
- IDLE:
  - If !init_done: stay; req_ready=0.
  - Else if ref_pending: go to REF. Refresh has priority over a simultaneous request.
  - Else req_ready=1. On handshake, latch req_rw and go to ACT.
- ACT: act_rdy=1 for one cycle. Load rcd_t=T_RCD-1 and clear ras_t. Go to WAIT_RCD.
  - CAS therefore occurs exactly T_RCD cycles after ACT.
- WAIT_RCD: decrement rcd_t; at 0 go to CAS.
- CAS:
  - cas_rdy=1 for one cycle.
  - Load data_t = rd_delay (READ) or wr_delay (WRITE), sampled this cycle.
  - Go to WAIT_DATA.
- WAIT_DATA:
  - When data_t reaches 0: rw_rdy=1 for one cycle, exactly delay cycles after cas_rdy.
  - If delay==0, rw_rdy fires in the cycle after CAS.
  - On the rw_rdy cycle, load post_t:
    - READ: bl/2
    - WRITE: bl/2 + T_WR
  - Then go to WAIT_PRE.
- WAIT_PRE: go to PRE when post_t==0 AND ras_t >= T_RAS-1.
  - ras_t counts cycles since ACT and saturates at all-ones (TW bits).
- PRE: pre_rdy=1 for one cycle. Load rp_t=T_RP-1. Go to WAIT_RP.
- WAIT_RP: at 0 return to IDLE.
- REF:
  - Only entered from IDLE, so all banks are precharged.
  - refresh_rdy=1 for one cycle; clear ref_pending.
  - Load rfc_t=T_RFC-1. Go to WAIT_RFC, which returns to IDLE at 0.
- Refresh interval counter:
  - Runs whenever init_done=1. Sets ref_pending at T_REFI-1, then wraps to 0.
  - If a second interval expires while ref_pending is still set, ref_pending stays 1. There is no postponement credit.
- Mutual exclusion: act_rdy, cas_rdy, pre_rdy and refresh_rdy are never asserted in the same cycle, and rw_rdy only in WAIT_DATA.
- Illegal req_rw (00/11): still accepted, sequenced as READ timing.
- Inputs rd_delay, wr_delay and bl are sampled only in CAS and WAIT_DATA. Changes mid-transaction do not affect timers already loaded.
- init_done falling mid-transaction: the current transaction completes; the scheduler then holds in IDLE.

Test Plan:
- Reset with init_done=0, req_valid=1 for 50 cycles -> req_ready=0, no strobes.
- Single READ, rd_delay=20, bl=8, defaults -> ACT@t, CAS@t+16, rw_rdy@t+36, pre_rdy@t+40 (post 4; tRAS 39 already met), next req_ready @t+56.
- Single WRITE, wr_delay=10, bl=8 -> CAS@t+16, rw_rdy@t+26, pre_rdy@t+48 (4+18), IDLE @t+64.
- tRAS-limited: READ, rd_delay=2, bl=4 -> rw_rdy@t+18, post done @t+20, pre_rdy held until t+39.
- Refresh collision: ref_pending and req_valid together in IDLE -> refresh_rdy first, req_ready low until 64 cycles later, then ACT.
- Async reset asserted in WAIT_DATA -> all outputs 0 immediately, no rw_rdy/pre_rdy after release, ref counter restarts from 0.
